// File: rtl/comparator_sweep_checker.sv
// Exhaustive sweep driver and checker for a WIDTH-bit magnitude comparator (EQ/GT/LT flags).
// Optional first-failure capture ports are enabled by defining COMPARATOR_SWEEP_FAIL_CAPTURE_EN.
module comparator_sweep_checker #(
   parameter int WIDTH         = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [WIDTH-1:0]   A,
   output logic [WIDTH-1:0]   B,
   input  logic               A_eq_B,
   input  logic               A_gt_B,
   input  logic               A_lt_B,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2*WIDTH:0]   err_count
`ifdef COMPARATOR_SWEEP_FAIL_CAPTURE_EN
   ,
   output logic               fail_valid,
   output logic [WIDTH-1:0]   fail_A,
   output logic [WIDTH-1:0]   fail_B,
   output logic [2:0]         fail_flags
`endif
);

   localparam int IDX_W = 2 * WIDTH;
   localparam int CNT_W = 4;
   // Clamp into the legal 1..15 range so the hold counter can never underflow.
   localparam int SETTLE_C = (SETTLE_CYCLES < 1) ? 1 : ((SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] WAIT_RELOAD = CNT_W'(SETTLE_C - 1);
   localparam logic [IDX_W-1:0] IDX_LAST    = '1;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      CHECK,
      DONE
   } state_t;

   state_t              state;
   logic [IDX_W-1:0]    idx;
   logic [CNT_W-1:0]    wait_cnt;
   logic [2:0]          flags_rx;
   logic                mismatch;

   function automatic logic [2:0] golden_flags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      return {a == b, a > b, a < b};
   endfunction

   function automatic logic [2*WIDTH:0] sat_inc(input logic [2*WIDTH:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   assign A        = idx[IDX_W-1:WIDTH];
   assign B        = idx[WIDTH-1:0];
   assign flags_rx = {A_eq_B, A_gt_B, A_lt_B};
   // Any flag pattern other than the golden one counts, including non-one-hot results.
   assign mismatch = (flags_rx != golden_flags(A, B));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         wait_cnt  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  idx       <= '0;
                  wait_cnt  <= WAIT_RELOAD;
                  err_count <= '0;
                  pass      <= 1'b0;
                  busy      <= 1'b1;
                  state     <= SETTLE;
               end
            end
            SETTLE: begin
               if (wait_cnt == '0) begin
                  state <= CHECK;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            CHECK: begin
               if (mismatch) begin
                  err_count <= sat_inc(err_count);
               end
               if (idx == IDX_LAST) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  idx      <= idx + 1'b1;
                  wait_cnt <= WAIT_RELOAD;
                  state    <= SETTLE;
               end
            end
            DONE: begin
               pass  <= (err_count == '0);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef COMPARATOR_SWEEP_FAIL_CAPTURE_EN
   // Holds only the first mismatching vector of a sweep; later failures leave it untouched.
   always_ff @(posedge clk) begin
      if (rst || (state == IDLE && start)) begin
         fail_valid <= 1'b0;
         fail_A     <= '0;
         fail_B     <= '0;
         fail_flags <= '0;
      end else if (state == CHECK && mismatch && !fail_valid) begin
         fail_valid <= 1'b1;
         fail_A     <= A;
         fail_B     <= B;
         fail_flags <= flags_rx;
      end
   end
`endif

endmodule

// File: tb/tb_comparator_sweep_checker.sv
// Scoreboard bench: two checker instances (settle 1 and settle 3) driving behavioural comparators.
module tb_comparator_sweep_checker;
   localparam int W = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;
   logic start1 = 1'b0, start3 = 1'b0;
   logic [W-1:0] a1, b1, a3, b3;
   logic eq1, gt1, lt1, eq3, gt3, lt3;
   logic busy1, done1, pass1, busy3, done3, pass3;
   logic [2*W:0] err1, err3;
`ifdef COMPARATOR_SWEEP_FAIL_CAPTURE_EN
   logic fv1, fv3;
   logic [W-1:0] fa1, fb1, fa3, fb3;
   logic [2:0] ff1, ff3;
`endif

   // comparator behaviour for dut1: 0 correct, 1 gt/lt swapped, 2 eq stuck 0, 3 two-cycle latency
   int mode = 0;
   logic [2:0] p1a, p1b, p3a, p3b;
   int cyc = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      p1a <= {a1 == b1, a1 > b1, a1 < b1};
      p1b <= p1a;
      p3a <= {a3 == b3, a3 > b3, a3 < b3};
      p3b <= p3a;
   end

   always_comb begin
      {eq1, gt1, lt1} = {a1 == b1, a1 > b1, a1 < b1};
      case (mode)
         1: {eq1, gt1, lt1} = {a1 == b1, a1 < b1, a1 > b1};
         2: eq1 = 1'b0;
         3: {eq1, gt1, lt1} = p1b;
         default: ;
      endcase
   end
   assign {eq3, gt3, lt3} = p3b;

   comparator_sweep_checker #(.WIDTH(W), .SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1),
      .A_eq_B(eq1), .A_gt_B(gt1), .A_lt_B(lt1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
`ifdef COMPARATOR_SWEEP_FAIL_CAPTURE_EN
      , .fail_valid(fv1), .fail_A(fa1), .fail_B(fb1), .fail_flags(ff1)
`endif
   );

   comparator_sweep_checker #(.WIDTH(W), .SETTLE_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .A(a3), .B(b3),
      .A_eq_B(eq3), .A_gt_B(gt3), .A_lt_B(lt3),
      .busy(busy3), .done(done3), .pass(pass3), .err_count(err3)
`ifdef COMPARATOR_SWEEP_FAIL_CAPTURE_EN
      , .fail_valid(fv3), .fail_A(fa3), .fail_B(fb3), .fail_flags(ff3)
`endif
   );

   typedef struct {
      logic [31:0] err;
      logic        chk_err;
      logic        pass;
      int          done_cyc;
      logic        cap_chk;
      logic        fv;
      logic [31:0] fa;
      logic [31:0] fb;
      logic [31:0] ff;
   } exp_t;

   exp_t q1[$];
   exp_t q3[$];
   int tests = 0;
   int fails = 0;
   logic pend1 = 1'b0, pend3 = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
      end
   endtask

   // dut1 monitor
   initial begin
      exp_t e;
      logic exp_pass;
      forever begin
         @(negedge clk);
         if (pend1) begin
            pend1 = 1'b0;
            chk("dut1_pass", 32'(pass1), 32'(exp_pass));
            chk("dut1_done_one_cycle", 32'(done1), 32'd0);
         end else if (done1) begin
            if (q1.size() == 0) begin
               chk("dut1_unexpected_done", 32'(done1), 32'd0);
            end else begin
               e = q1.pop_front();
               if (e.chk_err) chk("dut1_err_count", 32'(err1), e.err);
               else chk("dut1_err_nonzero", 32'(err1 != 0), 32'd1);
               chk("dut1_busy_at_done", 32'(busy1), 32'd0);
               chk("dut1_done_cycle", 32'(cyc), 32'(e.done_cyc));
`ifdef COMPARATOR_SWEEP_FAIL_CAPTURE_EN
               if (e.cap_chk) begin
                  chk("dut1_fail_valid", 32'(fv1), 32'(e.fv));
                  if (e.fv) begin
                     chk("dut1_fail_A", 32'(fa1), e.fa);
                     chk("dut1_fail_B", 32'(fb1), e.fb);
                     chk("dut1_fail_flags", 32'(ff1), e.ff);
                  end
               end
`endif
               exp_pass = e.pass;
               pend1 = 1'b1;
            end
         end
      end
   end

   // dut3 monitor
   initial begin
      exp_t e;
      logic exp_pass;
      forever begin
         @(negedge clk);
         if (pend3) begin
            pend3 = 1'b0;
            chk("dut3_pass", 32'(pass3), 32'(exp_pass));
            chk("dut3_done_one_cycle", 32'(done3), 32'd0);
         end else if (done3) begin
            if (q3.size() == 0) begin
               chk("dut3_unexpected_done", 32'(done3), 32'd0);
            end else begin
               e = q3.pop_front();
               chk("dut3_err_count", 32'(err3), e.err);
               chk("dut3_busy_at_done", 32'(busy3), 32'd0);
               chk("dut3_done_cycle", 32'(cyc), 32'(e.done_cyc));
`ifdef COMPARATOR_SWEEP_FAIL_CAPTURE_EN
               chk("dut3_fail_valid", 32'(fv3), 32'(e.fv));
`endif
               exp_pass = e.pass;
               pend3 = 1'b1;
            end
         end
      end
   end

   function automatic exp_t mk(input int err, input logic chk_err, input logic ps, input int dc,
                               input logic cc, input logic fv, input int fa, input int fb, input int ff);
      exp_t e;
      e.err = 32'(err); e.chk_err = chk_err; e.pass = ps; e.done_cyc = dc;
      e.cap_chk = cc; e.fv = fv; e.fa = 32'(fa); e.fb = 32'(fb); e.ff = 32'(ff);
      return e;
   endfunction

   task automatic post_start1_checks();
      chk("dut1_busy_after_start", 32'(busy1), 32'd1);
      chk("dut1_vector0", 32'({a1, b1}), 32'd0);
      chk("dut1_err_cleared", 32'(err1), 32'd0);
`ifdef COMPARATOR_SWEEP_FAIL_CAPTURE_EN
      chk("dut1_fail_valid_cleared", 32'(fv1), 32'd0);
`endif
   endtask

   task automatic start1_sweep(input int err, input logic chk_err, input logic ps,
                               input logic fv, input int fa, input int fb, input int ff);
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      post_start1_checks();
      q1.push_back(mk(err, chk_err, ps, cyc + 512, 1'b1, fv, fa, fb, ff));
   endtask

   task automatic wait1(input int maxc);
      for (int i = 0; i < maxc && (q1.size() != 0 || pend1); i++) @(negedge clk);
      if (q1.size() != 0 || pend1) begin
         chk("dut1_sweep_timeout_pending", 32'(q1.size()), 32'd0);
         q1.delete();
         pend1 = 1'b0;
      end
   endtask

   task automatic wait3(input int maxc);
      for (int i = 0; i < maxc && (q3.size() != 0 || pend3); i++) @(negedge clk);
      if (q3.size() != 0 || pend3) begin
         chk("dut3_sweep_timeout_pending", 32'(q3.size()), 32'd0);
         q3.delete();
         pend3 = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      repeat (3) @(negedge clk);
      chk("reset_A", 32'(a1), 32'd0);
      chk("reset_B", 32'(b1), 32'd0);
      chk("reset_busy", 32'(busy1), 32'd0);
      chk("reset_done", 32'(done1), 32'd0);
      chk("reset_pass", 32'(pass1), 32'd0);
      chk("reset_err", 32'(err1), 32'd0);
      chk("reset_busy3", 32'(busy3), 32'd0);
`ifdef COMPARATOR_SWEEP_FAIL_CAPTURE_EN
      chk("reset_fail_valid", 32'(fv1), 32'd0);
`endif
      rst = 1'b0;

      // settle 3 with two-cycle-latency comparator, alongside a correct settle 1 sweep
      @(negedge clk); start3 = 1'b1;
      @(negedge clk); start3 = 1'b0;
      chk("dut3_busy_after_start", 32'(busy3), 32'd1);
      q3.push_back(mk(0, 1'b1, 1'b1, cyc + 1024, 1'b1, 1'b0, 0, 0, 0));
      mode = 0;
      start1_sweep(0, 1'b1, 1'b1, 1'b0, 0, 0, 0);
      wait1(700);
      wait3(1200);

      mode = 1;
      start1_sweep(240, 1'b1, 1'b0, 1'b1, 0, 1, 3'b010);
      wait1(700);

      mode = 2;
      start1_sweep(16, 1'b1, 1'b0, 1'b1, 0, 0, 3'b000);
      wait1(700);

      // two-cycle latency is too slow for settle 1
      mode = 3;
      start1_sweep(0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
      q1[0].cap_chk = 1'b0;
      wait1(700);

      // abort mid-sweep with reset
      mode = 1;
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      repeat (100) @(negedge clk);
      chk("abort_err_before_reset_nonzero", 32'(err1 != 0), 32'd1);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("abort_A", 32'(a1), 32'd0);
      chk("abort_B", 32'(b1), 32'd0);
      chk("abort_busy", 32'(busy1), 32'd0);
      chk("abort_err", 32'(err1), 32'd0);
      chk("abort_done", 32'(done1), 32'd0);
      repeat (600) @(negedge clk);
      mode = 0;
      start1_sweep(0, 1'b1, 1'b1, 1'b0, 0, 0, 0);
      wait1(700);

      // mid-sweep start pulse ignored; start held through done restarts
      mode = 1;
      start1_sweep(240, 1'b1, 1'b0, 1'b1, 0, 1, 3'b010);
      repeat (50) @(negedge clk);
      start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      repeat (400) @(negedge clk);
      start1 = 1'b1;
      k = 0;
      while (!done1 && k < 200) begin @(negedge clk); k++; end
      chk("held_start_done_seen", 32'(done1), 32'd1);
      mode = 0;
      k = 0;
      while (!busy1 && k < 4) begin @(negedge clk); k++; end
      start1 = 1'b0;
      post_start1_checks();
      q1.push_back(mk(0, 1'b1, 1'b1, cyc + 512, 1'b1, 1'b0, 0, 0, 0));
      wait1(700);

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/comparator_sweep_checker.md
# comparator_sweep_checker

Self-checking exhaustive stimulus engine for the magnitude comparator: on a start pulse it drives every (A, B) operand pair into a comparator under test and samples its EQ/GT/LT flags after a programmable settle time. It checks the flags against a built-in golden model, counts mismatches and reports pass/fail. It is the driving and checking end of the comparator interface and replaces the hand-written vector lists used for on-board and regression checks of comparator instances.

## Interface
- WIDTH, 4: operand width; sweep covers 2^(2·WIDTH) pairs.
- SETTLE_CYCLES, 1: cycles an operand pair is held before sampling; legal range 1..15.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin sweep; honoured only in IDLE.
- A  out  WIDTH  operand A to comparator under test (registered).
- B  out  WIDTH  operand B to comparator under test (registered).
- A_eq_B  in  1  result flag from comparator under test.
- A_gt_B  in  1  result flag from comparator under test.
- A_lt_B  in  1  result flag from comparator under test.
- busy  out  1  high from start acceptance until DONE entry.
- done  out  1  one-cycle pulse at sweep end.
- pass  out  1  1 when last completed sweep had zero mismatches.
- err_count  out  2·WIDTH+1  mismatches in current/last sweep.

## Operation
- Vector index idx, 2·WIDTH bits: A = idx[2W-1:W], B = idx[W-1:0]; order A-major, B-minor, from 0 to 2^(2W)-1. No wrap: the last index ends the sweep.
- Golden model: eq = (A==B), gt = (A>B), lt = (A<B), unsigned.
- Mismatch when any of the three input flags differs from golden. This also covers non-one-hot flags. Each mismatching vector increments err_count by exactly 1. err_count cannot overflow.
- FSM states:
  - IDLE: busy=0. On start: idx←0, A=B=0, err_count←0, pass←0, wait counter←SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE: decrement wait counter; at 0 go to CHECK.
  - CHECK: sample flags, update err_count. If idx is last, go to DONE. Otherwise idx+1, reload wait counter, go to SETTLE.
  - DONE: done=1, pass←(err_count==0), go to IDLE.
- A/B hold the last vector after DONE until the next accepted start.
- start is ignored in SETTLE, CHECK and DONE; no queuing. start held high restarts one cycle after DONE.
- rst mid-sweep aborts immediately. No partial result is reported.

## Timing
- Reset values: A=0, B=0, busy=0, done=0, pass=0, err_count=0, state IDLE.
- Start accepted on edge E0: busy=1 and A/B=vector 0 visible after E0.
- Each vector is held SETTLE_CYCLES+1 cycles. Vector n is sampled at edge E0+(n+1)(SETTLE_CYCLES+1).
- Last sample edge: err_count is final after it, busy=0, and done=1 for the following cycle. pass is valid from the edge after that and holds until the next start.
- Total sweep for WIDTH=4, SETTLE_CYCLES=1: 512 cycles to last sample.
- Comparator under test may have registered latency up to SETTLE_CYCLES cycles from A/B change.

## Configuration
- COMPARATOR_SWEEP_FAIL_CAPTURE_EN defined: adds outputs fail_valid (1), fail_A (WIDTH), fail_B (WIDTH) and fail_flags (3, {eq,gt,lt} as received).
  - These capture the first mismatching vector of the sweep.
  - fail_valid sets on that sample edge. All four clear on reset and on start acceptance.
  - Later mismatches do not overwrite the capture.
- Not defined: these ports and registers are absent. All other behaviour is identical.

## Test plan
- Correct combinational comparator, WIDTH=4, SETTLE_CYCLES=1, start pulse -> done pulse after 512th sample edge, err_count=0, pass=1, busy low at done.
- Comparator with GT/LT swapped -> err_count=240, pass=0; capture gives fail_A=0, fail_B=1, fail_flags=3'b010.
- Comparator with A_eq_B stuck 0 -> err_count=16, pass=0; capture gives fail_A=0, fail_B=0, fail_flags=3'b000.
- rst asserted for one cycle after 100 cycles of a sweep -> next edge A=B=0, busy=0, err_count=0, no done. A new start restarts at vector 0 and a correct model passes.
- start pulsed again mid-sweep and held high through DONE -> mid-sweep pulse has no effect. A second sweep begins on the edge after the done cycle, and err_count clears at that acceptance.
- SETTLE_CYCLES=3 with a comparator having 2-cycle registered latency -> 4 cycles per vector, last sample at cycle 1024, err_count=0, pass=1. The same DUT with SETTLE_CYCLES=1 -> pass=0.
